// File: rtl/pipe_sink_if.sv
// Item stream between the last pipeline stage (master) and the sink (slave).
interface pipe_sink_if;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_stall;

   modport master (output in_valid, output in_data, input in_stall);
   modport slave  (input in_valid, input in_data, output in_stall);
endinterface

// File: rtl/pipe_sink.sv
// Receiving end of the pipeline test harness: applies pseudo-random
// back-pressure, checks accepted items against FIRST + i and reports
// completion / failure on sticky flags.
module pipe_sink #(
   parameter int unsigned NUM_ITEMS = 256,
   parameter logic [31:0] FIRST     = 32'h0000_0000,
   parameter bit          STALL_EN  = 1'b1,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic        clk,
   input  logic        rst,
   pipe_sink_if.slave  in_if,
   output logic [15:0] rcv_count,
   output logic [15:0] err_count,
   output logic        test_ended,
   output logic        test_error
);

   typedef enum logic {RUN, DONE} state_t;

   localparam logic [15:0] NUM_LAST = 16'(NUM_ITEMS);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  lfsr_q, lfsr_d;
   logic [31:0] exp_q, exp_d;
   logic [15:0] rcv_q, rcv_d;
   logic [15:0] err_q, err_d;
   logic [15:0] tmo_q, tmo_d;
   logic        ended_q, ended_d;
   logic        error_q, error_d;
   logic        stall;
   logic        accept;
   logic [15:0] rcv_inc;

   // Back-pressure and handshake decode from registered state only.
   always_comb begin
      stall = 1'b1;
      if (state_q == RUN) begin
         stall = STALL_EN & (lfsr_q[1:0] == 2'b00);
      end
      accept  = in_if.in_valid & ~stall & (state_q == RUN);
      rcv_inc = rcv_q + 16'd1;
   end

   assign in_if.in_stall = stall;

   // Next-state: item checking, completion, timeout and overrun detection.
   always_comb begin
      state_d = state_q;
      lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      exp_d   = exp_q;
      rcv_d   = rcv_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      ended_d = ended_q;
      error_d = error_q;
      case (state_q)
         RUN: begin
            if (accept) begin
               rcv_d = rcv_inc;
               exp_d = exp_q + 32'd1;
               tmo_d = '0;
               if (in_if.in_data != exp_q) begin
                  error_d = 1'b1;
                  if (err_q != 16'hFFFF) begin
                     err_d = err_q + 16'd1;
                  end
               end
               if (rcv_inc == NUM_LAST) begin
                  ended_d = 1'b1;
                  state_d = DONE;
               end
            end else if (tmo_q == TMO_LAST) begin
               error_d = 1'b1;
               ended_d = 1'b1;
               state_d = DONE;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         DONE: begin
            if (in_if.in_valid) begin
               error_d = 1'b1;
            end
         end
         default: state_d = DONE;
      endcase
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         lfsr_q  <= 8'h01;
         exp_q   <= FIRST;
         rcv_q   <= '0;
         err_q   <= '0;
         tmo_q   <= '0;
         ended_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         exp_q   <= exp_d;
         rcv_q   <= rcv_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
         ended_q <= ended_d;
         error_q <= error_d;
      end
   end

   assign rcv_count  = rcv_q;
   assign err_count  = err_q;
   assign test_ended = ended_q;
   assign test_error = error_q;

endmodule

// File: tb/tb_pipe_sink.sv
// Self-checking bench for pipe_sink: four parameterisations share one clock
// and reset; a reference model predicts in_stall and flags, and a scoreboard
// holds the expected counters for every accepted item.
module tb_pipe_sink;

   logic        clk = 1'b0;
   logic        rst;
   logic        vld;
   logic [31:0] dat;
   int unsigned sel;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   pipe_sink_if bus0 ();
   pipe_sink_if bus1 ();
   pipe_sink_if bus2 ();
   pipe_sink_if bus3 ();

   assign bus0.in_valid = vld && (sel == 0);
   assign bus1.in_valid = vld && (sel == 1);
   assign bus2.in_valid = vld && (sel == 2);
   assign bus3.in_valid = vld && (sel == 3);
   assign bus0.in_data  = dat;
   assign bus1.in_data  = dat;
   assign bus2.in_data  = dat;
   assign bus3.in_data  = dat;

   logic [15:0] rc0, rc1, rc2, rc3, ec0, ec1, ec2, ec3;
   logic        te0, te1, te2, te3, tr0, tr1, tr2, tr3;

   pipe_sink #(.NUM_ITEMS(4), .FIRST(32'h10), .STALL_EN(1'b0), .TIMEOUT(64)) u_basic (
      .clk(clk), .rst(rst), .in_if(bus0.slave), .rcv_count(rc0), .err_count(ec0),
      .test_ended(te0), .test_error(tr0));
   pipe_sink #(.NUM_ITEMS(256), .FIRST(32'h0), .STALL_EN(1'b1), .TIMEOUT(64)) u_stall (
      .clk(clk), .rst(rst), .in_if(bus1.slave), .rcv_count(rc1), .err_count(ec1),
      .test_ended(te1), .test_error(tr1));
   pipe_sink #(.NUM_ITEMS(4), .FIRST(32'h0), .STALL_EN(1'b0), .TIMEOUT(64)) u_small (
      .clk(clk), .rst(rst), .in_if(bus2.slave), .rcv_count(rc2), .err_count(ec2),
      .test_ended(te2), .test_error(tr2));
   pipe_sink #(.NUM_ITEMS(4), .FIRST(32'hFFFF_FFFE), .STALL_EN(1'b0), .TIMEOUT(64)) u_wrap (
      .clk(clk), .rst(rst), .in_if(bus3.slave), .rcv_count(rc3), .err_count(ec3),
      .test_ended(te3), .test_error(tr3));

   logic        o_stall, o_ended, o_error;
   logic [15:0] o_rcv, o_err;

   // Route the selected instance's outputs to the checker.
   always_comb begin
      o_stall = bus0.in_stall; o_rcv = rc0; o_err = ec0; o_ended = te0; o_error = tr0;
      case (sel)
         1: begin o_stall = bus1.in_stall; o_rcv = rc1; o_err = ec1; o_ended = te1; o_error = tr1; end
         2: begin o_stall = bus2.in_stall; o_rcv = rc2; o_err = ec2; o_ended = te2; o_error = tr2; end
         3: begin o_stall = bus3.in_stall; o_rcv = rc3; o_err = ec3; o_ended = te3; o_error = tr3; end
         default: ;
      endcase
   end

   function automatic bit p_stall_en();
      return sel == 1;
   endfunction

   function automatic int unsigned p_num();
      return (sel == 1) ? 256 : 4;
   endfunction

   function automatic logic [31:0] p_first();
      case (sel)
         0:       return 32'h10;
         3:       return 32'hFFFF_FFFE;
         default: return 32'h0;
      endcase
   endfunction

   // Reference model state
   logic [7:0]  m_lfsr;
   logic [31:0] m_exp;
   logic [15:0] m_rcv, m_err;
   int unsigned m_tmo;
   bit          m_done, m_ended, m_error;

   typedef struct {
      logic [15:0] rcv;
      logic [15:0] err;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Starts and ends just after a falling edge: drive, check the stall
   // prediction, clock, then compare the registered outputs.
   task automatic cycle(input logic v, input logic [31:0] d, output bit acc);
      bit   exp_stall;
      exp_t e;
      vld = v;
      dat = d;
      #1;
      exp_stall = m_done ? 1'b1 : (p_stall_en() && (m_lfsr[1:0] == 2'b00));
      check("in_stall", o_stall, exp_stall);
      acc = v && !exp_stall && !m_done;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      if (!m_done) begin
         if (acc) begin
            m_rcv++;
            if (d != m_exp) begin
               m_error = 1'b1;
               if (m_err != 16'hFFFF) m_err++;
            end
            m_exp++;
            m_tmo = 0;
            if (m_rcv == 16'(p_num())) begin
               m_done  = 1'b1;
               m_ended = 1'b1;
            end
            e.rcv = m_rcv;
            e.err = m_err;
            sb.push_back(e);
         end else if (m_tmo == 63) begin
            m_error = 1'b1;
            m_ended = 1'b1;
            m_done  = 1'b1;
         end else begin
            m_tmo++;
         end
      end else if (v) begin
         m_error = 1'b1;
      end
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("rcv_count", o_rcv, e.rcv);
         check("err_count", o_err, e.err);
      end
      check("test_ended", o_ended, m_ended);
      check("test_error", o_error, m_error);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      vld = 1'b0;
      @(posedge clk);
      #1;
      m_lfsr = 8'h01; m_exp = p_first(); m_rcv = '0; m_err = '0;
      m_tmo = 0; m_done = 1'b0; m_ended = 1'b0; m_error = 1'b0;
      sb.delete();
      check("rst_rcv", o_rcv, 0);
      check("rst_err", o_err, 0);
      check("rst_ended", o_ended, 0);
      check("rst_error", o_error, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Producer holds the item until the sink accepts it.
   task automatic send(input logic [31:0] d);
      bit acc = 1'b0;
      for (int i = 0; i < 100 && !acc; i++) cycle(1'b1, d, acc);
      if (!acc) check("send_bound", 0, 1);
      vld = 1'b0;
   endtask

   task automatic finals(input string tag, input logic [15:0] rcv, input logic [15:0] err,
                         input logic ended, input logic error);
      check({tag, "_rcv"}, o_rcv, rcv);
      check({tag, "_err"}, o_err, err);
      check({tag, "_ended"}, o_ended, ended);
      check({tag, "_error"}, o_error, error);
   endtask

   initial begin
      bit          acc;
      int unsigned k;
      logic [31:0] mis[4];
      rst = 1'b1; vld = 1'b0; dat = '0; sel = 0;
      @(negedge clk);

      // Back-to-back, no stall
      sel = 0;
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h10 + 32'(i), acc);
      vld = 1'b0;
      cycle(1'b0, '0, acc);
      finals("basic", 16'd4, 16'd0, 1'b1, 1'b0);
      // Overrun in DONE after a clean run
      cycle(1'b1, 32'h14, acc);
      cycle(1'b0, '0, acc);
      finals("overrun", 16'd4, 16'd0, 1'b1, 1'b1);

      // Pseudo-random stall, reset after 10 accepts, then full run
      sel = 1;
      do_reset();
      for (int i = 0; i < 10; i++) send(32'(i));
      do_reset();
      for (int i = 0; i < 256; i++) send(32'(i));
      cycle(1'b0, '0, acc);
      finals("stall", 16'd256, 16'd0, 1'b1, 1'b0);

      // Single mismatch
      sel = 2;
      do_reset();
      mis[0] = 32'd0; mis[1] = 32'd1; mis[2] = 32'd7; mis[3] = 32'd3;
      for (int i = 0; i < 4; i++) send(mis[i]);
      cycle(1'b0, '0, acc);
      finals("mismatch", 16'd4, 16'd1, 1'b1, 1'b1);

      // Timeout after two items, then overrun pulse
      do_reset();
      send(32'd0);
      send(32'd1);
      k = 0;
      for (int i = 1; i <= 200; i++) begin
         cycle(1'b0, '0, acc);
         if (o_ended && k == 0) k = i;
      end
      check("timeout_cycles", k, 64);
      finals("timeout", 16'd2, 16'd0, 1'b1, 1'b1);
      cycle(1'b1, 32'd2, acc);
      cycle(1'b0, '0, acc);
      finals("tmo_overrun", 16'd2, 16'd0, 1'b1, 1'b1);

      // Expected value wraps through zero
      sel = 3;
      do_reset();
      send(32'hFFFF_FFFE);
      send(32'hFFFF_FFFF);
      send(32'h0);
      send(32'h1);
      cycle(1'b0, '0, acc);
      finals("wrap", 16'd4, 16'd0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_sink.md
Name: pipe_sink

Overview:
- Receiving end of the pipeline test harness: consumes the data stream leaving the last stage of the pipeline under test.
- Applies pseudo-random back-pressure (stall) to exercise the stage-control logic.
- Checks every accepted item against the expected sequence; reports completion and failure on test_ended / test_error for the simulation top and board LEDs.

Parameters:
- NUM_ITEMS, 256: number of items to accept before the test ends (1..65535).
- FIRST, 32'h00000000: value of the first expected item; item i is expected to be FIRST + i (mod 2^32).
- STALL_EN, 1: 1 = pseudo-random stall generation enabled, 0 = in_stall held low while running.
- TIMEOUT, 64: maximum cycles in RUN without an accepted item before the test is aborted (>= 2).

Ports:
- clk  input  1  system clock
- rst  input  1  system reset, synchronous, active-high
- in_valid  input  1  last pipeline stage presents an item
- in_data  input  32  item data
- in_stall  output  1  sink refuses item this cycle (back-pressure)
- rcv_count  output  16  number of items accepted so far
- err_count  output  16  number of mismatching items (saturates at 16'hFFFF)
- test_ended  output  1  test finished (sticky until reset)
- test_error  output  1  test failed (sticky until reset)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high, sampled on posedge clk; overrides everything, including mid-test.
- Reset values:
  - state = RUN; rcv_count = 0; err_count = 0; test_ended = 0; test_error = 0.
  - Expected value register = FIRST; stall LFSR = 8'h01; timeout counter = 0.
- Stall LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances every non-reset cycle in every state.
- in_stall (combinational from registers):
  - RUN: STALL_EN & (lfsr[1:0] == 2'b00).
  - DONE: 1.
- Accept = in_valid & ~in_stall & (state == RUN). The item is consumed in the same cycle; no latency on the handshake.
- On accept:
  - rcv_count increments and the expected register increments (wraps 32'hFFFFFFFF -> 0).
  - If in_data != expected: err_count increments (saturating) and test_error <= 1.
- Completion: the accept that brings rcv_count to NUM_ITEMS moves state to DONE; test_ended <= 1 at that clock edge, visible the next cycle.
- Timeout:
  - The counter clears on each accept and increments on every other RUN cycle.
  - When it reaches TIMEOUT-1 and no accept occurs that cycle: test_error <= 1, test_ended <= 1, state <= DONE.
- DONE:
  - in_stall = 1; counters frozen.
  - in_valid == 1 in any DONE cycle is an overrun: test_error <= 1, err_count is unchanged.
  - Leaves only on rst.
- Simultaneous events:
  - Final accept with mismatch sets test_ended and test_error on the same edge.
  - Accept in the timeout cycle suppresses the timeout.
- in_valid while stalled is legal; the producer must hold the item. The sink does not check data stability.
- Outputs test_ended, test_error, rcv_count, err_count are registered.

Test Plan:
- STALL_EN=0, NUM_ITEMS=4, FIRST=32'h10: drive 0x10,0x11,0x12,0x13 back-to-back with in_valid=1 -> in_stall always 0, rcv_count=4, test_ended=1 one cycle after the 4th accept, test_error=0, err_count=0.
- STALL_EN=1, NUM_ITEMS=256, FIRST=0: producer holds each item until accepted -> in_stall follows LFSR pattern (first stall cycle where lfsr[1:0]=00), all 256 accepted, test_ended=1, test_error=0.
- Mismatch: NUM_ITEMS=4, FIRST=0, send 0,1,7,3 -> err_count=1, test_error=1 from cycle after 3rd accept, test_ended=1 after 4th accept, rcv_count=4.
- Wrap: FIRST=32'hFFFFFFFE, NUM_ITEMS=4, send FFFFFFFE, FFFFFFFF, 0, 1 -> no errors, test_ended=1.
- Timeout: TIMEOUT=64, STALL_EN=0, send 2 items then hold in_valid=0 -> test_error=1 and test_ended=1 exactly 64 cycles after last accept; rcv_count=2. Overrun: afterwards in DONE pulse in_valid -> in_stall=1, err_count unchanged.
- Reset mid-test: assert rst for one cycle after 10 accepts, then restart the sequence from FIRST -> all outputs return to 0 on the reset edge and the second run completes with test_error=0.
